// File: rtl/soc_system_fish_event_in.sv
// rtl/soc_system_fish_event_in.sv - FPGA-to-HPS fish-count record FIFO with Avalon-MM s1 slave and IRQ
module soc_system_fish_event_in #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DEPTH_LOG2:0] level;
    logic                empty;
    logic                full;
    logic                overflow;
    logic                irq_en;
    logic [15:0]         drop_cnt;
    logic                push;
    logic                pop;
    logic                drop;
    logic                clear;
    logic                irqen_wr;
    logic [31:0]         status;
    logic [31:0]         head;
    logic                unused_writedata;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    // A record arriving while full is lost, even if a pop frees a slot on the same edge.
    assign drop     = in_valid & full;
    assign pop      = chipselect & read & (address == 2'd0) & ~empty;
    assign clear    = chipselect & ~write_n & (address == 2'd3) & writedata[0];
    assign irqen_wr = chipselect & ~write_n & (address == 2'd2);

    assign unused_writedata = ^writedata[31:1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (clear) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            if (irqen_wr) begin
                irq_en <= writedata[0];
            end
            irq <= irq_en & ~empty;
        end
    end

    always_comb begin
        status                 = '0;
        status[DEPTH_LOG2:0]   = level;
        status[8]              = empty;
        status[9]              = full;
        status[10]             = overflow;
        status[31:16]          = drop_cnt;
    end

    always_comb begin
        head = '0;
        if (!empty) begin
            head[DATA_W-1:0] = mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = head;
            2'd1:    readdata = status;
            2'd2:    readdata = {31'd0, irq_en};
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_soc_system_fish_event_in.sv
// tb/tb_soc_system_fish_event_in.sv - scoreboard bench for soc_system_fish_event_in
module tb_soc_system_fish_event_in;
    localparam int KIND_RD    = 0;
    localparam int KIND_READY = 1;
    localparam int KIND_IRQ   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        irq;
    logic        chk = 1'b0;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    soc_system_fish_event_in #(.DATA_W(16), .DEPTH_LOG2(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation per flagged cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard_underflow: got a check strobe with no expectation queued");
            end else begin
                exp_t e;
                logic [31:0] act;
                e = exp_q.pop_front();
                case (e.kind)
                    KIND_READY: act = {31'd0, in_ready};
                    KIND_IRQ:   act = {31'd0, irq};
                    default:    act = readdata;
                endcase
                compared++;
                if (act !== e.val) begin
                    mismatched++;
                    $display("FAIL %s: got 32'h%08h, expected 32'h%08h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic expect_push(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] a, input logic [31:0] val, input string name);
        expect_push(KIND_RD, val, name);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        chk        = 1'b1;
        step();
        chipselect = 1'b0;
        read       = 1'b0;
        chk        = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic probe(input int kind, input logic val, input string name);
        expect_push(kind, {31'd0, val}, name);
        chk = 1'b1;
        step();
        chk = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic push_pop(input logic [15:0] d, input logic [31:0] val, input string name);
        in_valid = 1'b1;
        in_data  = d;
        read_reg(2'd0, val, name);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        // Reset state
        read_reg(2'd1, 32'h0000_0100, "reset_status");
        read_reg(2'd0, 32'h0000_0000, "reset_data");
        probe(KIND_READY, 1'b1, "reset_in_ready");
        probe(KIND_IRQ, 1'b0, "reset_irq");

        // Basic push/pop
        push(16'h0005);
        push(16'h0007);
        read_reg(2'd1, 32'h0000_0002, "basic_level2");
        read_reg(2'd0, 32'h0000_0005, "basic_data0");
        read_reg(2'd1, 32'h0000_0001, "basic_level1");
        read_reg(2'd0, 32'h0000_0007, "basic_data1");
        read_reg(2'd1, 32'h0000_0100, "basic_empty");

        // Fill past capacity with in_valid held
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 16'h0010 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        probe(KIND_READY, 1'b0, "fill_in_ready");
        read_reg(2'd1, 32'h0001_0608, "fill_status");
        write_reg(2'd3, 32'h1);
        read_reg(2'd1, 32'h0000_0208, "fill_cleared");
        for (int i = 0; i < 8; i++) begin
            read_reg(2'd0, 32'h0000_0010 + 32'(i), $sformatf("fill_drain%0d", i));
        end
        read_reg(2'd1, 32'h0000_0100, "fill_drained");

        // Pointer wrap at 1-2 entries of occupancy
        push(16'd1);
        for (int v = 2; v <= 20; v++) begin
            push(16'(v));
            read_reg(2'd0, 32'(v - 1), $sformatf("wrap_%0d", v - 1));
        end
        read_reg(2'd0, 32'd20, "wrap_20");
        read_reg(2'd1, 32'h0000_0100, "wrap_empty");

        // IRQ timing
        write_reg(2'd2, 32'h1);
        probe(KIND_IRQ, 1'b0, "irq_en_empty");
        read_reg(2'd2, 32'h1, "irqen_readback");
        push(16'h0055);
        probe(KIND_IRQ, 1'b0, "irq_push_edge");
        probe(KIND_IRQ, 1'b1, "irq_asserted");
        read_reg(2'd0, 32'h0000_0055, "irq_data");
        probe(KIND_IRQ, 1'b1, "irq_pop_edge");
        probe(KIND_IRQ, 1'b0, "irq_deasserted");
        write_reg(2'd2, 32'h0);

        // Simultaneous push+pop at level 3
        push(16'h0031);
        push(16'h0032);
        push(16'h0033);
        push_pop(16'h0034, 32'h0000_0031, "mid_pushpop_data");
        read_reg(2'd1, 32'h0000_0003, "mid_pushpop_level");

        // Simultaneous push+pop at full: push is dropped
        for (int i = 0; i < 5; i++) begin
            push(16'h0035 + 16'(i));
        end
        read_reg(2'd1, 32'h0000_0208, "full_status");
        push_pop(16'h00AA, 32'h0000_0032, "full_pushpop_data");
        read_reg(2'd1, 32'h0001_0407, "full_pushpop_status");

        // CLEAR wins over a same-edge drop
        push(16'h003A);
        read_reg(2'd1, 32'h0001_0608, "refill_status");
        in_valid = 1'b1;
        in_data  = 16'h00BB;
        write_reg(2'd3, 32'h1);
        in_valid = 1'b0;
        read_reg(2'd1, 32'h0000_0208, "clear_vs_drop");

        // Asynchronous reset mid-stream
        reset_n = 1'b0;
        read_reg(2'd1, 32'h0000_0100, "async_reset_status");
        probe(KIND_READY, 1'b1, "async_reset_in_ready");
        reset_n = 1'b1;
        step();
        read_reg(2'd1, 32'h0000_0100, "post_reset_status");
        read_reg(2'd0, 32'h0000_0000, "post_reset_data");

        step();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
